// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and RAM-side signals around the shared memory port.
// The slave modport is the arbiter's view; master is the view of the requesters plus RAM.
interface mem_port_arbiter_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
);
    logic                 IfReq;
    logic [AddrWidth-1:0] IfAddr;
    logic                 IfReady;
    logic [DataWidth-1:0] IfData;

    logic                 MemReq;
    logic                 MemWe;
    logic [AddrWidth-1:0] MemAddr;
    logic [DataWidth-1:0] MemWdata;
    logic [3:0]           MemWmask;
    logic                 MemReady;
    logic [DataWidth-1:0] MemRdata;

    logic                 RamValid;
    logic                 RamWe;
    logic [AddrWidth-1:0] RamAddr;
    logic [DataWidth-1:0] RamWdata;
    logic [3:0]           RamWmask;
    logic                 RamAck;
    logic [DataWidth-1:0] RamRdata;

    logic                 Busy;

    modport slave (
        input  IfReq, IfAddr, MemReq, MemWe, MemAddr, MemWdata, MemWmask, RamAck, RamRdata,
        output IfReady, IfData, MemReady, MemRdata,
        output RamValid, RamWe, RamAddr, RamWdata, RamWmask, Busy
    );

    modport master (
        output IfReq, IfAddr, MemReq, MemWe, MemAddr, MemWdata, MemWmask, RamAck, RamRdata,
        input  IfReady, IfData, MemReady, MemRdata,
        input  RamValid, RamWe, RamAddr, RamWdata, RamWmask, Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one RAM port between instruction fetch and the Mem stage.
// One access at a time: arbitrate in IDLE, hold the RAM command until ack,
// then pulse the owner's ready for one cycle with the read data registered.
// Mem normally wins; a wait counter forces an IF grant after StarveLimit
// consecutive Mem grants taken while IF was waiting.
module mem_port_arbiter #(
    parameter int AddrWidth   = 64,
    parameter int DataWidth   = 64,
    parameter int StarveLimit = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           wait_cnt;

    logic                 ram_valid;
    logic                 ram_we;
    logic [AddrWidth-1:0] ram_addr;
    logic [DataWidth-1:0] ram_wdata;
    logic [3:0]           ram_wmask;
    logic [DataWidth-1:0] resp_data;
    logic                 if_ready;
    logic                 mem_ready;

    logic                 if_starved;
    logic                 mem_win;
    logic                 if_win;

    // IF overrides Mem only once it has been passed over StarveLimit times in a row
    assign if_starved = bus.IfReq && (wait_cnt == 4'(StarveLimit));
    assign mem_win    = bus.MemReq && !if_starved;
    assign if_win     = bus.IfReq && !mem_win;

    // Next-state logic: arbitrate in IDLE, wait for ack, one response cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (mem_win)     state_nxt = BUSY_MEM;
                else if (if_win) state_nxt = BUSY_IF;
            end
            BUSY_IF, BUSY_MEM: begin
                if (bus.RamAck) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Command latching, response capture, ready pulses and starvation counter
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wait_cnt  <= '0;
            ram_valid <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wmask <= '0;
            resp_data <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_win) begin
                        ram_valid <= 1'b1;
                        ram_we    <= bus.MemWe;
                        ram_addr  <= bus.MemAddr;
                        ram_wdata <= bus.MemWdata;
                        ram_wmask <= bus.MemWe ? bus.MemWmask : 4'b0000;
                        wait_cnt  <= bus.IfReq ? (wait_cnt + 4'd1) : 4'd0;
                    end else if (if_win) begin
                        ram_valid <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= bus.IfAddr;
                        ram_wdata <= '0;
                        ram_wmask <= 4'b0000;
                        wait_cnt  <= 4'd0;
                    end else begin
                        wait_cnt  <= 4'd0;
                    end
                end
                BUSY_IF, BUSY_MEM: begin
                    if (bus.RamAck) begin
                        ram_valid <= 1'b0;
                        if (!ram_we) resp_data <= bus.RamRdata;
                        if_ready  <= (state == BUSY_IF);
                        mem_ready <= (state == BUSY_MEM);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.RamValid = ram_valid;
    assign bus.RamWe    = ram_we;
    assign bus.RamAddr  = ram_addr;
    assign bus.RamWdata = ram_wdata;
    assign bus.RamWmask = ram_wmask;
    assign bus.IfReady  = if_ready;
    assign bus.IfData   = resp_data;
    assign bus.MemReady = mem_ready;
    assign bus.MemRdata = resp_data;
    assign bus.Busy     = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters and RAM checked every cycle against a
// transaction-level model of the shared port.
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SL = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    mem_port_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    mem_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .StarveLimit(SL)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    // Model of the port: one command in flight, then one response cycle
    bit          m_inflight;
    bit          m_respond;
    bit          m_owner_mem;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [3:0]  m_wmask;
    logic [63:0] m_rdata;
    bit          m_if_rdy;
    bit          m_mem_rdy;
    int          m_wait;
    bit          m_done_if;
    bit          m_done_mem;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight = 0; m_respond = 0; m_owner_mem = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_wmask = '0; m_rdata = '0;
        m_if_rdy = 0; m_mem_rdy = 0; m_wait = 0; m_done_if = 0; m_done_mem = 0;
    endtask

    task automatic model_step();
        m_done_if  = 0;
        m_done_mem = 0;
        if (!Rst) begin
            model_reset();
        end else if (m_respond) begin
            m_respond = 0; m_if_rdy = 0; m_mem_rdy = 0;
            if (m_owner_mem) m_done_mem = 1; else m_done_if = 1;
        end else if (m_inflight) begin
            if (bus.RamAck) begin
                m_inflight = 0;
                m_respond  = 1;
                if (!m_we) m_rdata = bus.RamRdata;
                if (m_owner_mem) m_mem_rdy = 1; else m_if_rdy = 1;
            end
        end else begin
            if (bus.MemReq && !(bus.IfReq && m_wait == SL)) begin
                m_inflight = 1; m_owner_mem = 1;
                m_we = bus.MemWe; m_addr = bus.MemAddr; m_wdata = bus.MemWdata;
                m_wmask = bus.MemWe ? bus.MemWmask : 4'b0000;
                m_wait = bus.IfReq ? m_wait + 1 : 0;
            end else if (bus.IfReq) begin
                m_inflight = 1; m_owner_mem = 0;
                m_we = 0; m_addr = bus.IfAddr; m_wdata = '0; m_wmask = 4'b0000;
                m_wait = 0;
            end else begin
                m_wait = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge Clk) begin
        if (cmp_on) begin
            chk("RamValid", bus.RamValid, m_inflight);
            chk("Busy", bus.Busy, m_inflight | m_respond);
            chk("IfReady", bus.IfReady, m_if_rdy);
            chk("MemReady", bus.MemReady, m_mem_rdy);
            chk("IfData", bus.IfData, m_rdata);
            chk("MemRdata", bus.MemRdata, m_rdata);
            if (m_inflight) begin
                chk("RamWe", bus.RamWe, m_we);
                chk("RamAddr", bus.RamAddr, m_addr);
                chk("RamWmask", bus.RamWmask, m_wmask);
                if (m_we) chk("RamWdata", bus.RamWdata, m_wdata);
            end
        end
    end

    logic [63:0] grants [$];
    logic [63:0] exp_grants [10];
    int          busy_cycles;
    bit          prev_valid;

    initial begin
        bus.IfReq = 0; bus.IfAddr = '0; bus.MemReq = 0; bus.MemWe = 0; bus.MemAddr = '0;
        bus.MemWdata = '0; bus.MemWmask = '0; bus.RamAck = 0; bus.RamRdata = '0;
        model_reset();
        #1 Rst = 1'b0;
        tick();
        cmp_on = 1'b1;
        tick();
        @(negedge Clk);
        chk("reset_RamValid", bus.RamValid, 0);
        chk("reset_Busy", bus.Busy, 0);
        chk("reset_MemRdata", bus.MemRdata, 0);
        chk("reset_IfReady", bus.IfReady, 0);
        Rst = 1'b1;

        // Single load, RAM acks in the first command cycle
        bus.MemReq = 1; bus.MemWe = 0; bus.MemAddr = 64'h8000_0010;
        bus.RamAck = 1; bus.RamRdata = 64'h1122334455667788;
        tick();
        @(negedge Clk);
        chk("load_RamValid", bus.RamValid, 1);
        chk("load_RamWmask", bus.RamWmask, 4'b0000);
        chk("load_RamAddr", bus.RamAddr, 64'h8000_0010);
        tick();
        bus.RamAck = 0;
        @(negedge Clk);
        chk("load_MemReady", bus.MemReady, 1);
        chk("load_MemRdata", bus.MemRdata, 64'h1122334455667788);
        chk("load_IfReady", bus.IfReady, 0);
        chk("load_RamValid_drop", bus.RamValid, 0);
        chk("model_rdata_pin", m_rdata, 64'h1122334455667788);
        bus.MemReq = 0;
        tick();
        @(negedge Clk);
        chk("load_MemReady_end", bus.MemReady, 0);
        chk("load_idle", bus.Busy, 0);

        // Store with a three-cycle RAM latency
        bus.MemReq = 1; bus.MemWe = 1; bus.MemAddr = 64'h8000_0020;
        bus.MemWdata = 64'hDEAD; bus.MemWmask = 4'b0010; bus.RamAck = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("store_RamValid", bus.RamValid, 1);
            chk("store_RamAddr", bus.RamAddr, 64'h8000_0020);
            chk("store_RamWdata", bus.RamWdata, 64'hDEAD);
            chk("store_RamWmask", bus.RamWmask, 4'b0010);
            chk("store_MemReady_early", bus.MemReady, 0);
            bus.IfAddr = 64'h1234_0000 + 64'(k);
            if (k == 2) bus.RamAck = 1;
            tick();
        end
        bus.RamAck = 0;
        @(negedge Clk);
        chk("store_MemReady", bus.MemReady, 1);
        chk("store_MemRdata_kept", bus.MemRdata, 64'h1122334455667788);
        bus.MemReq = 0; bus.MemWe = 0; bus.MemWmask = 0;
        tick();

        // IF-only fetch, RAM acks in the second command cycle
        bus.IfReq = 1; bus.IfAddr = 64'h8000_0000; bus.RamRdata = 64'h13; bus.RamAck = 0;
        tick();
        busy_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            if (bus.Busy) busy_cycles++;
            if (c == 0) chk("fetch_RamAddr", bus.RamAddr, 64'h8000_0000);
            if (c == 1) begin chk("fetch_IfReady_early", bus.IfReady, 0); bus.RamAck = 1; end
            if (c == 2) begin
                chk("fetch_IfReady", bus.IfReady, 1);
                chk("fetch_IfData", bus.IfData, 64'h13);
                chk("fetch_MemReady", bus.MemReady, 0);
                bus.RamAck = 0; bus.IfReq = 0;
            end
            if (c == 3) chk("fetch_IfReady_end", bus.IfReady, 0);
            tick();
        end
        chk("fetch_busy_cycles", 64'(busy_cycles), 64'd3);

        // Spurious acks in IDLE
        bus.RamAck = 1; bus.RamRdata = 64'hBAD0_BAD0;
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge Clk);
            chk("spur_idle_Busy", bus.Busy, 0);
            chk("spur_idle_IfReady", bus.IfReady, 0);
            chk("spur_idle_MemReady", bus.MemReady, 0);
            chk("spur_idle_data", bus.IfData, 64'h13);
        end
        // Spurious ack during RESP
        bus.IfReq = 1; bus.IfAddr = 64'h8000_0040; bus.RamRdata = 64'h55;
        tick();
        tick();
        bus.RamRdata = 64'h77; bus.IfReq = 0;
        @(negedge Clk);
        chk("spur_resp_IfReady", bus.IfReady, 1);
        chk("spur_resp_IfData", bus.IfData, 64'h55);
        tick();
        @(negedge Clk);
        chk("spur_after_IfReady", bus.IfReady, 0);
        chk("spur_after_IfData", bus.IfData, 64'h55);
        chk("spur_after_Busy", bus.Busy, 0);
        bus.RamAck = 0;
        tick();

        // Both requesters held, RAM acks immediately: starvation guard
        bus.IfReq = 1; bus.IfAddr = 64'h200;
        bus.MemReq = 1; bus.MemWe = 0; bus.MemAddr = 64'h100;
        bus.RamAck = 1; bus.RamRdata = 64'h99;
        prev_valid = 0;
        grants.delete();
        for (int c = 0; c < 32; c++) begin
            tick();
            @(negedge Clk);
            if (bus.RamValid && !prev_valid) grants.push_back(bus.RamAddr);
            prev_valid = bus.RamValid;
        end
        exp_grants = '{64'h100, 64'h100, 64'h100, 64'h100, 64'h200,
                       64'h100, 64'h100, 64'h100, 64'h100, 64'h200};
        chk("starve_grant_count", 64'(grants.size() >= 10), 64'd1);
        for (int g = 0; g < 10; g++) begin
            if (g < grants.size()) chk($sformatf("starve_grant%0d", g), grants[g], exp_grants[g]);
        end
        bus.IfReq = 0; bus.MemReq = 0; bus.RamAck = 0;
        repeat (4) tick();

        // Reset while a Mem command is waiting for an ack that never comes
        bus.MemReq = 1; bus.MemWe = 0; bus.MemAddr = 64'h300; bus.RamAck = 0;
        tick();
        tick();
        chk("rstmid_Busy_before", bus.Busy, 1);
        chk("rstmid_RamValid_before", bus.RamValid, 1);
        Rst = 1'b0;
        model_reset();
        #1;
        chk("rstmid_RamValid", bus.RamValid, 0);
        chk("rstmid_Busy", bus.Busy, 0);
        chk("rstmid_RamAddr", bus.RamAddr, 0);
        chk("rstmid_MemRdata", bus.MemRdata, 0);
        chk("rstmid_MemReady", bus.MemReady, 0);
        bus.MemReq = 0;
        tick();
        tick();
        @(negedge Clk);
        Rst = 1'b1;
        bus.MemReq = 1; bus.MemAddr = 64'h400; bus.RamAck = 1; bus.RamRdata = 64'hCAFE;
        tick();
        @(negedge Clk);
        chk("post_rst_RamValid", bus.RamValid, 1);
        chk("post_rst_RamAddr", bus.RamAddr, 64'h400);
        tick();
        @(negedge Clk);
        chk("post_rst_MemReady", bus.MemReady, 1);
        chk("post_rst_MemRdata", bus.MemRdata, 64'hCAFE);
        bus.MemReq = 0; bus.RamAck = 0;
        tick();

        // Randomized requesters (held until served) and a randomly acking RAM
        for (int i = 0; i < 3000; i++) begin
            if (!bus.IfReq || m_done_if) begin
                bus.IfReq  = ($urandom_range(0, 2) != 0);
                bus.IfAddr = {$urandom, $urandom};
            end
            if (!bus.MemReq || m_done_mem) begin
                bus.MemReq   = ($urandom_range(0, 2) != 0);
                bus.MemWe    = $urandom_range(0, 1) == 1;
                bus.MemAddr  = {$urandom, $urandom};
                bus.MemWdata = {$urandom, $urandom};
                bus.MemWmask = 4'b0001 << $urandom_range(0, 3);
            end
            bus.RamAck   = ($urandom_range(0, 2) == 0);
            bus.RamRdata = {$urandom, $urandom};
            tick();
        end

        @(negedge Clk);
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
